// File: rtl/dmem_access_unit.sv
// dmem_access_unit: load/store front end for the 1 KiB byte-addressed data memory.
// The memory always writes a full 4-byte word at the given byte address, so
// byte/half stores are done as read-modify-write of the word at that address.
module dmem_access_unit #(
  parameter int ALLOW_MISALIGNED = 0,
  parameter int MEM_BYTES        = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [9:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        dmem_enable,
  output logic        dmem_read_write,
  output logic [9:0]  dmem_address,
  output logic [31:0] dmem_data_in,
  input  logic [31:0] dmem_data_out
);

  // state    | meaning
  // IDLE     | waiting for a request, req_ready high
  // ISSUE_RD | memory read strobe (loads and the read half of sub-word stores)
  // WAIT_RD  | read word present on dmem_data_out; extend it or merge store data
  // ISSUE_WR | memory write strobe
  // RESP     | one-cycle response pulse
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE_RD = 3'd1,
    S_WAIT_RD  = 3'd2,
    S_ISSUE_WR = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  state_t      r_state;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_error;
  logic [31:0] r_resp_rdata;
  logic        r_dmem_enable;
  logic        r_dmem_read_write;
  logic [31:0] r_dmem_data_in;
  logic [9:0]  r_addr;
  logic [1:0]  r_size;
  logic        r_signed;
  logic        r_write;
  logic [31:0] r_wdata;

  logic [2:0]  w_nbytes;
  logic [31:0] w_last_byte;
  logic        w_misaligned;
  logic        w_req_error;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  // classify the incoming request: byte count, alignment and range errors
  always_comb begin
    case (req_size)
      SZ_BYTE: w_nbytes = 3'd1;
      SZ_HALF: w_nbytes = 3'd2;
      default: w_nbytes = 3'd4;
    endcase
    w_last_byte  = 32'(req_addr) + 32'(w_nbytes) - 32'd1;
    w_misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                   ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    w_req_error  = (req_size == SZ_BAD) ||
                   ((ALLOW_MISALIGNED == 0) && w_misaligned) ||
                   (w_last_byte > 32'(MEM_BYTES - 1));
  end

  // extend load data and build the read-modify-write word from the read data
  always_comb begin
    case (r_size)
      SZ_BYTE: begin
        w_load_data = {{24{r_signed & dmem_data_out[7]}}, dmem_data_out[7:0]};
        w_merged    = {dmem_data_out[31:8], r_wdata[7:0]};
      end
      SZ_HALF: begin
        w_load_data = {{16{r_signed & dmem_data_out[15]}}, dmem_data_out[15:0]};
        w_merged    = {dmem_data_out[31:16], r_wdata[15:0]};
      end
      default: begin
        w_load_data = dmem_data_out;
        w_merged    = r_wdata;
      end
    endcase
  end

  // sequencing FSM; every output is a register updated on the transition into its state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_req_ready       <= 1'b1;
      r_resp_valid      <= 1'b0;
      r_resp_error      <= 1'b0;
      r_resp_rdata      <= 32'd0;
      r_dmem_enable     <= 1'b0;
      r_dmem_read_write <= 1'b0;
      r_dmem_data_in    <= 32'd0;
      r_addr            <= 10'd0;
      r_size            <= 2'b00;
      r_signed          <= 1'b0;
      r_write           <= 1'b0;
      r_wdata           <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_req_ready  <= 1'b0;
            r_addr       <= req_addr;
            r_size       <= req_size;
            r_signed     <= req_signed;
            r_write      <= req_write;
            r_wdata      <= req_wdata;
            r_resp_rdata <= 32'd0;
            r_resp_error <= w_req_error;
            if (w_req_error) begin
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else if (req_write && (req_size == SZ_WORD)) begin
              r_dmem_enable     <= 1'b1;
              r_dmem_read_write <= 1'b1;
              r_dmem_data_in    <= req_wdata;
              r_state           <= S_ISSUE_WR;
            end else begin
              r_dmem_enable     <= 1'b1;
              r_dmem_read_write <= 1'b0;
              r_dmem_data_in    <= 32'd0;
              r_state           <= S_ISSUE_RD;
            end
          end
        end
        S_ISSUE_RD: begin
          r_dmem_enable <= 1'b0;
          r_state       <= S_WAIT_RD;
        end
        S_WAIT_RD: begin
          if (r_write) begin
            r_dmem_enable     <= 1'b1;
            r_dmem_read_write <= 1'b1;
            r_dmem_data_in    <= w_merged;
            r_state           <= S_ISSUE_WR;
          end else begin
            r_resp_rdata <= w_load_data;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_ISSUE_WR: begin
          r_dmem_enable     <= 1'b0;
          r_dmem_read_write <= 1'b0;
          r_dmem_data_in    <= 32'd0;
          r_resp_valid      <= 1'b1;
          r_state           <= S_RESP;
        end
        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: begin
          r_dmem_enable     <= 1'b0;
          r_dmem_read_write <= 1'b0;
          r_dmem_data_in    <= 32'd0;
          r_resp_valid      <= 1'b0;
          r_req_ready       <= 1'b1;
          r_state           <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready       = r_req_ready;
  assign resp_valid      = r_resp_valid;
  assign resp_error      = r_resp_error;
  assign resp_rdata      = r_resp_rdata;
  assign dmem_enable     = r_dmem_enable;
  assign dmem_read_write = r_dmem_read_write;
  assign dmem_address    = r_addr;
  assign dmem_data_in    = r_dmem_data_in;

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Load/store front end directly upstream of the byte-addressed 1 KiB data memory. Sits between the execute stage and the data memory.
- Takes byte/halfword/word load and store requests over a valid/ready handshake.
- Drives the memory's enable / read_write / 10-bit address / 32-bit write-data port and consumes its registered 32-bit little-endian read word.
- Performs sign/zero extension, read-modify-write for sub-word stores (the memory always writes 4 bytes), and alignment/range error checks.

Parameters:
- ALLOW_MISALIGNED, 0, 1 = permit halfword/word at any byte address (range check still applies); 0 = flag misaligned accesses as errors.
- MEM_BYTES, 1024, memory size in bytes; the range check uses addr + nbytes - 1 <= MEM_BYTES-1.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  input  1  loads only: 1 = sign-extend.
- req_addr  input  10  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  one-cycle pulse per accepted request.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_error  output  1  valid with resp_valid.
- dmem_enable  output  1  memory enable.
- dmem_read_write  output  1  1 = write, 0 = read.
- dmem_address  output  10  memory byte address; always the latched req_addr.
- dmem_data_in  output  32  memory write data.
- dmem_data_out  input  32  memory read data; valid the cycle after a read is issued.

Behaviour:
- States: IDLE, ISSUE_RD, WAIT_RD, ISSUE_WR, RESP.
- Handshake: the request is accepted when req_valid && req_ready, in IDLE only. Address, size, signed, write and wdata are latched on acceptance; later request-input changes are ignored.
- Error decode at acceptance:
  - Error if size==11.
  - Error if misaligned (half with addr[0]; word with addr[1:0]!=0) while ALLOW_MISALIGNED=0.
  - Error if addr+nbytes-1 > MEM_BYTES-1.
  - On error: IDLE->RESP with resp_error=1 and resp_rdata=0. No dmem_enable ever asserted.
- Load: IDLE->ISSUE_RD->WAIT_RD->RESP.
  - ISSUE_RD: dmem_enable=1, dmem_read_write=0.
  - WAIT_RD: capture dmem_data_out[7:0] (byte) or [15:0] (half), sign- or zero-extend per req_signed; word is taken whole.
  - resp_valid rises 3 cycles after the acceptance edge.
- Word store: IDLE->ISSUE_WR->RESP. ISSUE_WR: dmem_enable=1, dmem_read_write=1, dmem_data_in=wdata. Response 2 cycles after acceptance.
- Sub-word store: IDLE->ISSUE_RD->WAIT_RD->ISSUE_WR->RESP.
  - WAIT_RD: merge = read word with [7:0] (byte) or [15:0] (half) replaced by wdata.
  - ISSUE_WR: writes the merged word. Response 4 cycles after acceptance.
  - The upper bytes written back must equal those read.
- RESP: resp_valid=1 for exactly one cycle, then IDLE; req_ready=1 again the next cycle. Maximum throughput: one request per 3 (word store) to 5 (sub-word store) cycles.
- dmem_enable is high only in ISSUE_RD/ISSUE_WR; otherwise dmem_read_write=0 and dmem_data_in=0.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, dmem_enable=0, dmem_read_write=0, dmem_address=0, dmem_data_in=0.
- Reset mid-operation: the state returns to IDLE on that edge and the request is dropped with no response. A write issued before the reset edge is not undone; no write is issued after it.
- req_valid with reset high is not accepted.

Test Plan:
- Memory preloaded with word4=0x99127254, word8=0x12345678, word12=0x89117843. Signed byte load at addr 7 -> resp_rdata=0xFFFFFF99, resp_error=0, resp_valid 3 cycles after acceptance.
- Unsigned half load at addr 4 -> 0x00007254. Signed half at addr 6 -> 0xFFFF9912. Word at 8 -> 0x12345678.
- Byte store 0x000000AB at addr 9 -> one read then one write at address 9 with dmem_data_in=0x431234AB, response at +4. Then word load at 8 -> 0x1234AB78, and word load at 12 unchanged at 0x89117843.
- ALLOW_MISALIGNED=0: word load at addr 6, half store at 5, size=11 -> resp_error=1, resp_rdata=0, response 1 cycle after acceptance, dmem_enable never high. ALLOW_MISALIGNED=1: word at 1022 -> error (range); word at 1020 -> ok.
- Back-to-back: req_valid held high with word store 0xDEADBEEF@16, then word load @16 -> second request accepted only after RESP, load returns 0xDEADBEEF, req_ready low throughout each operation.
- Reset asserted during WAIT_RD of a sub-word store -> no resp_valid, no write issued, all outputs at reset values the next cycle, and a new load accepted and correct afterward.
